ezp_uart_tx: RTL and testbench

EZPack packet transmitter: the transmit-side counterpart of the EZPack UART receive path. Accepts one fully assembled EZPack packet image per valid/ready handshake, emits it byte-serially as 8N1 UART frames, and transmits only the bytes the packet's LEN field makes live. Sits between a packet source (FIFO or host logic) and the board TX pin. Contains its own packet buffer, byte sequencer, optional checksum generator and baud-rate bit engine.

---
 rtl/ezp_uart_tx.sv | 100 ++++++++++
 tb/tb_ezp_uart_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ezp_uart_tx.sv
// ezp_uart_tx: EZPack packet transmitter emitting LEN-sized packets as 8N1 UART frames; EZP_TX_CHKSUM_EN regenerates CHK
module ezp_uart_tx #(
  parameter logic [7:0] START_BYTE = 8'hAA,
  parameter logic [7:0] END_BYTE = 8'h55,
  parameter int MAX_PD_LEN = 2,
  parameter int MAX_PKTLEN = MAX_PD_LEN + 5,
  parameter int CLK_RATE = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int NCLKS_PER_BIT = CLK_RATE / BAUD_RATE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*MAX_PKTLEN-1:0] i_data,
  input  logic                    i_valid,
  output logic                    i_ready,
  output logic                    o_tx_data,
  output logic                    o_busy,
  output logic                    o_err
);
  localparam int IW = $clog2(MAX_PKTLEN);
  localparam int BW = $clog2(NCLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, LOAD, SEND} state_t;
  state_t state;
  logic [8*MAX_PKTLEN-1:0] pkt;
  logic [IW-1:0] idx;
  logic [3:0] bit_cnt;
  logic [BW-1:0] baud;
  logic [7:0] len, last, idx8, cur;
  assign len = pkt[23:16];
  assign last = len + 8'd4;
  assign idx8 = 8'(idx);
`ifdef EZP_TX_CHKSUM_EN
  logic [7:0] sum;
  // mod-256 sum of CMD, LEN and the live payload bytes
  always_comb begin
    sum = 8'h00;
    for (int k = 1; k < MAX_PKTLEN; k++)
      if (k <= int'(len) + 2) sum = sum + pkt[8*k +: 8];
  end
  assign cur = idx8 == 8'd0 ? START_BYTE : idx8 == last ? END_BYTE :
               idx8 == last - 8'd1 ? sum : pkt[8*idx +: 8];
`else
  assign cur = idx8 == 8'd0 ? START_BYTE : idx8 == last ? END_BYTE : pkt[8*idx +: 8];
`endif
  // packet sequencer and bit engine; the next bit is registered as one bit period ends
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pkt <= '0;
      idx <= '0;
      bit_cnt <= '0;
      baud <= '0;
      o_tx_data <= 1'b1;
      i_ready <= 1'b1;
      o_busy <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_err <= 1'b0;
      case (state)
        IDLE: if (i_valid) begin
          pkt <= i_data;
          i_ready <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          idx <= '0;
          bit_cnt <= '0;
          baud <= '0;
          if (len > 8'(MAX_PD_LEN)) begin
            state <= IDLE;
            o_err <= 1'b1;
            i_ready <= 1'b1;
          end else begin
            state <= SEND;
            o_tx_data <= 1'b0;
            o_busy <= 1'b1;
          end
        end
        SEND: if (baud != BW'(NCLKS_PER_BIT - 1)) baud <= baud + 1'b1;
        else begin
          baud <= '0;
          if (bit_cnt != 4'd9) begin
            bit_cnt <= bit_cnt + 1'b1;
            o_tx_data <= bit_cnt == 4'd8 ? 1'b1 : cur[bit_cnt[2:0]];
          end else if (idx8 == last) begin
            state <= IDLE;
            o_tx_data <= 1'b1;
            i_ready <= 1'b1;
            o_busy <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
            bit_cnt <= '0;
            o_tx_data <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ezp_uart_tx.sv
// tb_ezp_uart_tx: table-driven directed bench for ezp_uart_tx at 4 clocks per bit
module tb_ezp_uart_tx;
  logic clk = 0, rst = 1, i_valid = 0;
  logic [55:0] i_data = '0;
  logic i_ready, o_tx_data, o_busy, o_err;
  int n_vec = 0, n_bad = 0;
`ifdef EZP_TX_CHKSUM_EN
  localparam bit CS = 1;
`else
  localparam bit CS = 0;
`endif
  typedef struct {
    logic [7:0] b[7];
    logic [7:0] e[7];
    int n;
    logic err;
  } vec_t;
  vec_t v[5];

  ezp_uart_tx #(.NCLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .o_tx_data(o_tx_data), .o_busy(o_busy), .o_err(o_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] img(input logic [7:0] b[7]);
    logic [55:0] r;
    for (int k = 0; k < 7; k++) r[8*k +: 8] = b[k];
    return r;
  endfunction

  // present a packet, complete the handshake and advance to cycle T+2
  task automatic go(input logic [55:0] im, input logic [55:0] after, input logic keep);
    i_data = im;
    i_valid = 1;
    for (int c = 0; c < 5000 && i_ready !== 1'b1; c++) begin
      @(posedge clk);
      #1;
    end
    if (i_ready !== 1'b1) chk("ready_wait", 32'(i_ready), 1);
    @(posedge clk);
    #1;
    i_data = after;
    i_valid = keep;
    chk("ready_drop", 32'(i_ready), 0);
    @(posedge clk);
    #1;
  endtask

  // starting at the first start-bit cycle, sample every bit mid-period
  task automatic decode(input logic [7:0] e[7], input int n);
    logic [9:0] fr;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 10; j++) begin
        repeat (2) @(posedge clk);
        #1;
        fr[j] = o_tx_data;
        @(posedge clk);
        #1;
        if (i == n - 1 && j == 9) chk("busy_last", {30'd0, o_busy, i_ready}, 32'b10);
        @(posedge clk);
        #1;
      end
      chk($sformatf("frame%0d", i), 32'(fr), 32'({1'b1, e[i], 1'b0}));
    end
    chk("end_state", {29'd0, i_ready, o_busy, o_tx_data}, 32'b101);
  endtask

  task automatic run(input vec_t x);
    go(img(x.b), ~img(x.b), 0);
    if (x.err) begin
      chk("err_t2", {28'd0, o_err, i_ready, o_busy, o_tx_data}, 32'b1101);
      @(posedge clk);
      #1;
      chk("err_pulse", 32'(o_err), 0);
      begin
        int bad = 0;
        for (int c = 0; c < 20; c++) begin
          if (o_tx_data !== 1'b1 || o_err !== 1'b0 || o_busy !== 1'b0) bad++;
          @(posedge clk);
          #1;
        end
        chk("err_quiet", bad, 0);
      end
    end else begin
      chk("start_t2", {30'd0, o_busy, o_tx_data}, 32'b10);
      decode(x.e, x.n);
    end
  endtask

  initial begin
    v[0].b = '{8'hFF, 8'h12, 8'h02, 8'h34, 8'h56, 8'h77, 8'hFF};
    v[0].e = '{8'hAA, 8'h12, 8'h02, 8'h34, 8'h56, CS ? 8'h9E : 8'h77, 8'h55};
    v[0].n = 7; v[0].err = 0;
    v[1].b = '{8'hAA, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00};
    v[1].e = '{8'hAA, 8'h01, 8'h00, 8'h01, 8'h55, 8'h00, 8'h00};
    v[1].n = 5; v[1].err = 0;
    v[2].b = '{8'h00, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'h55, 8'h00};
    v[2].e = '{8'hAA, 8'hA5, 8'h01, 8'h3C, CS ? 8'hE2 : 8'h00, 8'h55, 8'h00};
    v[2].n = 6; v[2].err = 0;
    v[3].b = '{8'hAA, 8'h12, 8'h03, 8'h34, 8'h56, 8'h78, 8'h9A};
    v[3].e = '{default: 8'h00};
    v[3].n = 0; v[3].err = 1;
    v[4].b = '{8'hAA, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h55};
    v[4].e = '{default: 8'h00};
    v[4].n = 0; v[4].err = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {28'd0, o_tx_data, i_ready, o_busy, o_err}, 32'b1100);
    rst = 0;
    begin
      int bad = 0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk);
        #1;
        if (o_tx_data !== 1'b1 || i_ready !== 1'b1 || o_busy !== 1'b0) bad++;
      end
      chk("idle_100", bad, 0);
    end
    for (int i = 0; i < 5; i++) run(v[i]);
    // back-to-back: image changes right after capture and i_valid stays high
    go(img(v[0].b), img(v[2].b), 1);
    chk("b2b_start", {30'd0, o_busy, o_tx_data}, 32'b10);
    decode(v[0].e, v[0].n);
    go(img(v[2].b), 56'd0, 0);
    chk("b2b_second", {30'd0, o_busy, o_tx_data}, 32'b10);
    decode(v[2].e, v[2].n);
    // reset during the third data bit of the LEN byte, then a clean packet
    go(img(v[0].b), 56'd0, 0);
    repeat (93) @(posedge clk);
    #1;
    chk("mid_bit", {30'd0, o_busy, o_tx_data}, 32'b10);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("rst_mid", {29'd0, o_tx_data, i_ready, o_busy}, 32'b110);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_idle", {30'd0, o_tx_data, o_busy}, 32'b10);
    run(v[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
